// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction memory read port, redirect/enable controls
// and the valid/ready instruction stream towards decode.
interface instr_fetch_ctrl_if;
  logic        fetch_en_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i;

  // master: the fetch controller; slave: the memory/pipeline around it
  modport master (
    input  fetch_en_i, imem_data_i, redirect_i, redirect_pc_i, ready_i,
    output imem_addr_o, instr_o, pc_o, valid_o
  );

  modport slave (
    output fetch_en_i, imem_data_i, redirect_i, redirect_pc_i, ready_i,
    input  imem_addr_o, instr_o, pc_o, valid_o
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: walks the PC through a combinational instruction memory and
// queues {pc, instr} pairs for decode in a small FIFO, with redirect and enable gating.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic                clk_i,
  input logic                rst_i,
  instr_fetch_ctrl_if.master bus
);
  localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   pc_reg, pc_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [31:0]   entry_pc_reg    [DEPTH];
  logic [31:0]   entry_instr_reg [DEPTH];
  logic          pop, push;

  // A redirect discards the head, so it suppresses both pop and push.
  assign bus.valid_o     = (count_reg != '0);
  assign pop             = bus.valid_o & bus.ready_i & ~bus.redirect_i;
  assign push            = bus.fetch_en_i & ~bus.redirect_i & ((count_reg < FULL) | pop);
  assign bus.imem_addr_o = pc_reg;
  assign bus.instr_o     = entry_instr_reg[rd_ptr_reg];
  assign bus.pc_o        = entry_pc_reg[rd_ptr_reg];

  always_comb begin
    pc_next     = pc_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (bus.redirect_i) begin
      pc_next     = bus.redirect_pc_i & 32'hFFFF_FFFC;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        pc_next     = pc_reg + 32'd4;
        wr_ptr_next = wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      if (push && !pop) begin
        count_next = count_reg + CW'(1);
      end else if (pop && !push) begin
        count_next = count_reg - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_reg     <= RESET_PC;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      pc_reg     <= pc_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entries are cleared on reset so the head outputs never show X.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          entry_pc_reg[gi]    <= '0;
          entry_instr_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == AW'(gi))) begin
          entry_pc_reg[gi]    <= pc_reg;
          entry_instr_reg[gi] <= bus.imem_data_i;
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus a randomized
// run against a queue-based model of the fetch stream.
module tb_instr_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] rpc = '0;
  logic        ready = 1'b0;
  logic        hash_mode = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  ent_t        q[$];
  logic [31:0] m_pc = RESET_PC;

  always #5 clk = ~clk;

  instr_fetch_ctrl_if bus ();

  assign bus.fetch_en_i    = en;
  assign bus.redirect_i    = redir;
  assign bus.redirect_pc_i = rpc;
  assign bus.ready_i       = ready;
  assign bus.imem_data_i   = hash_mode ? ((bus.imem_addr_o * 32'h9E37_79B1) ^ 32'h5A5A_1234)
                                       : bus.imem_addr_o;

  instr_fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic h);
    return h ? ((a * 32'h9E37_79B1) ^ 32'h5A5A_1234) : a;
  endfunction

  // Advance one clock edge, applying the fetch rules to the model, then settle.
  task automatic step();
    bit do_pop, do_push;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_pc = RESET_PC;
    end else if (redir) begin
      q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      do_pop  = (q.size() != 0) && ready;
      do_push = en && ((q.size() < DEPTH) || do_pop);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back('{pc: m_pc, instr: mem_word(m_pc, hash_mode)});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; ready = 1'b0; redir = 1'b0;
    step(); step();
    n_checks++;
    if (bus.valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.valid_o);
    else n_pass++;
    n_checks++;
    if (bus.imem_addr_o !== RESET_PC) $display("FAIL reset_addr: got %h expected %h", bus.imem_addr_o, RESET_PC);
    else n_pass++;
    n_checks++;
    if (bus.pc_o !== 32'h0) $display("FAIL reset_pc_o: got %h expected 0", bus.pc_o);
    else n_pass++;
    n_checks++;
    if (bus.instr_o !== 32'h0) $display("FAIL reset_instr_o: got %h expected 0", bus.instr_o);
    else n_pass++;
  endtask

  task automatic test_streaming();
    rst = 1'b0; en = 1'b1; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (bus.valid_o !== 1'b1) $display("FAIL stream_valid[%0d]: got %b expected 1", i, bus.valid_o);
      else n_pass++;
      n_checks++;
      if (bus.pc_o !== 32'(4 * i) || bus.instr_o !== 32'(4 * i))
        $display("FAIL stream_word[%0d]: got pc %h instr %h expected %h", i, bus.pc_o, bus.instr_o, 32'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    rst = 1'b1; en = 1'b1; ready = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (int'(dut.count_reg) != 2) $display("FAIL bp_count: got %0d expected 2", dut.count_reg);
    else n_pass++;
    n_checks++;
    if (bus.imem_addr_o !== 32'd8) $display("FAIL bp_pc_hold: got %h expected 8", bus.imem_addr_o);
    else n_pass++;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'(4 * i))
        $display("FAIL bp_resume[%0d]: got valid %b pc %h expected pc %h", i, bus.valid_o, bus.pc_o, 32'(4 * i));
      else n_pass++;
      step();
    end
  endtask

  task automatic test_redirect();
    ready = 1'b0; en = 1'b1;
    step(); step();
    n_checks++;
    if (int'(dut.count_reg) != 2) $display("FAIL redir_full: got %0d expected 2", dut.count_reg);
    else n_pass++;
    redir = 1'b1; rpc = 32'h0000_0103;
    step();
    redir = 1'b0;
    n_checks++;
    if (bus.valid_o !== 1'b0) $display("FAIL redir_valid: got %b expected 0", bus.valid_o);
    else n_pass++;
    n_checks++;
    if (bus.imem_addr_o !== 32'h100) $display("FAIL redir_addr: got %h expected 00000100", bus.imem_addr_o);
    else n_pass++;
    ready = 1'b1;
    step();
    n_checks++;
    if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h100)
      $display("FAIL redir_first: got valid %b pc %h expected pc 00000100", bus.valid_o, bus.pc_o);
    else n_pass++;
  endtask

  task automatic test_enable_gating();
    logic [31:0] held;
    ready = 1'b1; en = 1'b1;
    step(); step();
    held = m_pc;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bus.imem_addr_o !== held) $display("FAIL gate_hold[%0d]: got %h expected %h", i, bus.imem_addr_o, held);
      else n_pass++;
    end
    n_checks++;
    if (bus.valid_o !== 1'b0) $display("FAIL gate_drain: got valid %b expected 0", bus.valid_o);
    else n_pass++;
    en = 1'b1;
    step();
    n_checks++;
    if (bus.valid_o !== 1'b1 || bus.pc_o !== held)
      $display("FAIL gate_resume: got valid %b pc %h expected pc %h", bus.valid_o, bus.pc_o, held);
    else n_pass++;
  endtask

  task automatic test_wrap();
    ready = 1'b0; en = 1'b1;
    redir = 1'b1; rpc = 32'hFFFF_FFF8;
    step();
    redir = 1'b0;
    step(); step();
    n_checks++;
    if (bus.imem_addr_o !== 32'h0) $display("FAIL wrap_addr: got %h expected 00000000", bus.imem_addr_o);
    else n_pass++;
    ready = 1'b1;
    n_checks++;
    if (bus.pc_o !== 32'hFFFF_FFF8) $display("FAIL wrap_pc0: got %h expected fffffff8", bus.pc_o);
    else n_pass++;
    step();
    n_checks++;
    if (int'(dut.count_reg) != 2) $display("FAIL wrap_full_popush: got count %0d expected 2", dut.count_reg);
    else n_pass++;
    n_checks++;
    if (bus.pc_o !== 32'hFFFF_FFFC) $display("FAIL wrap_pc1: got %h expected fffffffc", bus.pc_o);
    else n_pass++;
    step();
    n_checks++;
    if (bus.pc_o !== 32'h0000_0000) $display("FAIL wrap_pc2: got %h expected 00000000", bus.pc_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    ready = 1'b0; en = 1'b1;
    step(); step();
    n_checks++;
    if (int'(dut.count_reg) != 2) $display("FAIL rstmid_full: got %0d expected 2", dut.count_reg);
    else n_pass++;
    rst = 1'b1; redir = 1'b1; rpc = 32'h0000_0500;
    step();
    rst = 1'b0; redir = 1'b0;
    n_checks++;
    if (bus.valid_o !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", bus.valid_o);
    else n_pass++;
    n_checks++;
    if (bus.imem_addr_o !== RESET_PC) $display("FAIL rstmid_addr: got %h expected %h", bus.imem_addr_o, RESET_PC);
    else n_pass++;
  endtask

  task automatic test_random();
    hash_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(99) < 1);
      en    = ($urandom_range(99) < 80);
      ready = ($urandom_range(99) < 60);
      redir = ($urandom_range(99) < 5);
      rpc   = $urandom;
      step();
      n_checks++;
      if (bus.valid_o !== (q.size() != 0) || bus.imem_addr_o !== m_pc)
        $display("FAIL rand_state[%0d]: got valid %b addr %h expected valid %b addr %h",
                 i, bus.valid_o, bus.imem_addr_o, q.size() != 0, m_pc);
      else n_pass++;
      if (q.size() != 0) begin
        n_checks++;
        if (bus.pc_o !== q[0].pc || bus.instr_o !== q[0].instr)
          $display("FAIL rand_head[%0d]: got pc %h instr %h expected pc %h instr %h",
                   i, bus.pc_o, bus.instr_o, q[0].pc, q[0].instr);
        else n_pass++;
      end
    end
    rst = 1'b0; redir = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_enable_gating();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
